jy_irq_counter: RTL and testbench

JY_IRQ_COUNTER -- requirements
Module: jy_irq_counter

---
 rtl/jy_pkg.sv | 38 +++
 rtl/edge_sync.sv | 56 +++++
 rtl/jy_irq_counter.sv | 135 +++++++++++++
 tb/tb_jy_irq_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/jy_pkg.sv
// rtl/jy_pkg.sv - shared register offsets, tick-source and direction encodings for jy_irq_counter
package jy_pkg;

  localparam logic [2:0] OFF_ENABLE    = 3'd0;
  localparam logic [2:0] OFF_MODE      = 3'd1;
  localparam logic [2:0] OFF_DISABLE   = 3'd2;
  localparam logic [2:0] OFF_ENABLE_ON = 3'd3;
  localparam logic [2:0] OFF_PRESCALER = 3'd4;
  localparam logic [2:0] OFF_COUNTER   = 3'd5;
  localparam logic [2:0] OFF_XOR       = 3'd6;

  typedef enum logic [1:0] {
    SRC_M2  = 2'b00,
    SRC_A12 = 2'b01,
    SRC_RD  = 2'b10,
    SRC_CPU = 2'b11
  } tick_src_e;

  typedef enum logic [1:0] {
    DIR_HALT = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_HOLD = 2'b11
  } dir_e;

  // Mode bits 5:3 have no function, so only the meaningful fields are kept.
  typedef struct packed {
    dir_e      dir;
    logic      narrow;
    tick_src_e src;
  } mode_t;

  function automatic logic [7:0] load_xform(input logic [7:0] d, input logic [7:0] xorv,
                                            input logic up);
    return d ^ xorv ^ {8{up}};
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchroniser with rise or fall strobe, optional minimum-low qualifier
module edge_sync #(
  parameter bit          FALL    = 1'b0,
  parameter int unsigned LOW_MIN = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_raw;
  logic w_qual;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign w_raw = FALL ? (r_prev & ~r_sync) : (r_sync & ~r_prev);

  generate
    if (LOW_MIN == 0) begin : g_nofilt
      assign w_qual = 1'b1;
    end else begin : g_filt
      localparam int unsigned LW = $clog2(LOW_MIN + 1);
      logic [LW-1:0] r_low;

      // Saturating run length of synchronised-low cycles; it holds the count for the rise cycle.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_low <= '0;
        end else if (r_sync) begin
          r_low <= '0;
        end else if (r_low != LW'(LOW_MIN)) begin
          r_low <= r_low + 1'b1;
        end
      end

      assign w_qual = (r_low == LW'(LOW_MIN));
    end
  endgenerate

  assign o_edge = w_raw & w_qual;

endmodule

// File: rtl/jy_irq_counter.sv
// rtl/jy_irq_counter.sv - cartridge IRQ prescaler/counter with selectable tick source and direction
module jy_irq_counter
  import jy_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN = 3
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        ppu_a12,
  input  logic        ppu_rd_n,
  input  logic        cpu_wr_evt,
  output logic        irq_n,
  output logic [15:0] dbg_count
);

  logic       r_enable;
  logic       r_pending;
  logic       r_irq_n;
  mode_t      r_mode;
  logic [7:0] r_xorv;
  logic [7:0] r_pre;
  logic [7:0] r_cnt;

  logic       w_a12_rise;
  logic       w_rd_fall;
  logic       w_up;
  logic       w_down;
  logic       w_tick_raw;
  logic       w_load;
  logic       w_tick;
  logic [7:0] w_pmax;
  logic [7:0] w_pfield;
  logic [7:0] w_pnext_f;
  logic [7:0] w_pnext;
  logic [7:0] w_cnext;
  logic       w_pwrap;
  logic       w_cwrap;
  logic       w_clear;
  logic       w_pend_nxt;
  logic [7:0] w_load_val;

  edge_sync #(.FALL(1'b0), .LOW_MIN(A12_LOW_MIN)) u_a12_sync (
    .i_clk   (m2),
    .i_rst_n (rst_n),
    .i_async (ppu_a12),
    .o_edge  (w_a12_rise)
  );

  edge_sync #(.FALL(1'b1), .LOW_MIN(0)) u_rd_sync (
    .i_clk   (m2),
    .i_rst_n (rst_n),
    .i_async (ppu_rd_n),
    .o_edge  (w_rd_fall)
  );

  always_comb begin
    w_up       = (r_mode.dir == DIR_UP);
    w_down     = (r_mode.dir == DIR_DOWN);
    w_tick_raw = 1'b0;
    case (r_mode.src)
      SRC_M2:  w_tick_raw = 1'b1;
      SRC_A12: w_tick_raw = w_a12_rise;
      SRC_RD:  w_tick_raw = w_rd_fall;
      default: w_tick_raw = cpu_wr_evt;
    endcase
    // A direct load of prescaler or counter swallows a simultaneous tick.
    w_load = wr_en && ((wr_addr == OFF_PRESCALER) || (wr_addr == OFF_COUNTER));
    w_tick = w_tick_raw && (w_up || w_down) && !w_load;

    w_pmax   = r_mode.narrow ? 8'h07 : 8'hFF;
    w_pfield = r_mode.narrow ? {5'b00000, r_pre[2:0]} : r_pre;
    w_cnext  = r_cnt;
    w_cwrap  = 1'b0;
    if (w_up) begin
      w_pwrap   = (w_pfield == w_pmax);
      w_pnext_f = w_pwrap ? 8'h00 : (w_pfield + 8'd1);
      if (w_pwrap) begin
        w_cwrap = (r_cnt == 8'hFF);
        w_cnext = r_cnt + 8'd1;
      end
    end else begin
      w_pwrap   = (w_pfield == 8'h00);
      w_pnext_f = w_pwrap ? w_pmax : (w_pfield - 8'd1);
      if (w_pwrap) begin
        w_cwrap = (r_cnt == 8'h00);
        w_cnext = r_cnt - 8'd1;
      end
    end
    w_pnext = r_mode.narrow ? {r_pre[7:3], w_pnext_f[2:0]} : w_pnext_f;

    w_clear    = wr_en && ((wr_addr == OFF_DISABLE) || ((wr_addr == OFF_ENABLE) && !wr_data[0]));
    w_pend_nxt = !w_clear && (r_pending || (w_tick && w_cwrap && r_enable));
    w_load_val = load_xform(wr_data, r_xorv, w_up);
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      r_enable  <= 1'b0;
      r_pending <= 1'b0;
      r_irq_n   <= 1'b1;
      r_mode    <= '0;
      r_xorv    <= 8'h00;
      r_pre     <= 8'h00;
      r_cnt     <= 8'h00;
    end else begin
      r_pending <= w_pend_nxt;
      r_irq_n   <= ~w_pend_nxt;
      if (w_tick) begin
        r_pre <= w_pnext;
        r_cnt <= w_cnext;
      end
      if (wr_en) begin
        case (wr_addr)
          OFF_ENABLE:    r_enable <= wr_data[0];
          OFF_MODE:      r_mode   <= '{dir:    dir_e'(wr_data[7:6]),
                                       narrow: wr_data[2],
                                       src:    tick_src_e'(wr_data[1:0])};
          OFF_DISABLE:   r_enable <= 1'b0;
          OFF_ENABLE_ON: r_enable <= 1'b1;
          OFF_PRESCALER: r_pre    <= w_load_val;
          OFF_COUNTER:   r_cnt    <= w_load_val;
          OFF_XOR:       r_xorv   <= wr_data;
          default:       ;
        endcase
      end
    end
  end

  assign irq_n     = r_irq_n;
  assign dbg_count = {r_cnt, r_pre};

endmodule

// File: tb/tb_jy_irq_counter.sv
// tb/tb_jy_irq_counter.sv - directed vector bench for jy_irq_counter
module tb_jy_irq_counter;

  logic        m2;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        ppu_a12;
  logic        ppu_rd_n;
  logic        cpu_wr_evt;
  logic        irq_n;
  logic [15:0] dbg_count;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  data;
    logic        evt;
    int          idle;
    logic [15:0] exp_dbg;
    logic        exp_irq_n;
  } vec_t;

  vec_t vt[$];

  jy_irq_counter #(.A12_LOW_MIN(3)) dut (
    .m2         (m2),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ppu_a12    (ppu_a12),
    .ppu_rd_n   (ppu_rd_n),
    .cpu_wr_evt (cpu_wr_evt),
    .irq_n      (irq_n),
    .dbg_count  (dbg_count)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write is taken on the following posedge.
  task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic e);
    wr_en      = 1'b1;
    wr_addr    = a;
    wr_data    = d;
    cpu_wr_evt = e;
    @(negedge m2);
    wr_en      = 1'b0;
    cpu_wr_evt = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge m2);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'h00;
    ppu_a12 = 1'b0;
    ppu_rd_n = 1'b1;
    cpu_wr_evt = 1'b0;

    // Down, every m2, 3-bit prescaler: prescaler bits 7:3 must hold.
    vt.push_back('{3'd1, 8'h04, 1'b0, 0, 16'h0000, 1'b1});
    vt.push_back('{3'd4, 8'hFB, 1'b0, 0, 16'h00FB, 1'b1});
    vt.push_back('{3'd5, 8'h01, 1'b0, 0, 16'h01FB, 1'b1});
    vt.push_back('{3'd0, 8'h01, 1'b0, 0, 16'h01FB, 1'b1});
    vt.push_back('{3'd1, 8'h84, 1'b0, 0, 16'h01FB, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b0, 2, 16'h01F8, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b0, 0, 16'h00FF, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b0, 6, 16'h00F8, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b0, 0, 16'hFFFF, 1'b0});
    vt.push_back('{3'd1, 8'h04, 1'b0, 0, 16'hFFFE, 1'b0});
    vt.push_back('{3'd0, 8'h00, 1'b0, 0, 16'hFFFE, 1'b1});
    // Up, cpu_wr_evt source, xor 5A with up-inversion on loads.
    vt.push_back('{3'd6, 8'h5A, 1'b0, 0, 16'hFFFE, 1'b1});
    vt.push_back('{3'd1, 8'h43, 1'b0, 0, 16'hFFFE, 1'b1});
    vt.push_back('{3'd4, 8'h00, 1'b0, 0, 16'hFFA5, 1'b1});
    vt.push_back('{3'd5, 8'hA5, 1'b0, 0, 16'h00A5, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b1, 0, 16'h00A6, 1'b1});
    vt.push_back('{3'd5, 8'h5A, 1'b1, 0, 16'hFFA6, 1'b1});
    vt.push_back('{3'd4, 8'h5A, 1'b1, 0, 16'hFFFF, 1'b1});
    vt.push_back('{3'd0, 8'h01, 1'b1, 0, 16'h0000, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b0, 0, 16'h0000, 1'b1});
    vt.push_back('{3'd4, 8'h5A, 1'b0, 0, 16'h00FF, 1'b1});
    vt.push_back('{3'd5, 8'h5A, 1'b0, 0, 16'hFFFF, 1'b1});
    vt.push_back('{3'd2, 8'h00, 1'b1, 0, 16'h0000, 1'b1});
    vt.push_back('{3'd3, 8'h00, 1'b0, 0, 16'h0000, 1'b1});
    vt.push_back('{3'd4, 8'h5A, 1'b0, 0, 16'h00FF, 1'b1});
    vt.push_back('{3'd5, 8'h5A, 1'b0, 0, 16'hFFFF, 1'b1});
    vt.push_back('{3'd7, 8'h00, 1'b1, 0, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 8'h01, 1'b0, 0, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 8'h00, 1'b0, 0, 16'h0000, 1'b1});

    idle(2);
    chk("reset dbg", dbg_count, 16'h0000);
    chk("reset irq", {15'd0, irq_n}, 16'h0001);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      do_write(vt[i].addr, vt[i].data, vt[i].evt);
      idle(vt[i].idle);
      chk($sformatf("v%0d dbg", i), dbg_count, vt[i].exp_dbg);
      chk($sformatf("v%0d irq", i), {15'd0, irq_n}, {15'd0, vt[i].exp_irq_n});
    end

    // Async reset while irq is asserted and counting every m2.
    do_write(3'd3, 8'h00, 1'b0);
    do_write(3'd4, 8'h5A, 1'b0);
    do_write(3'd5, 8'h5A, 1'b0);
    do_write(3'd7, 8'h00, 1'b1);
    do_write(3'd1, 8'h40, 1'b0);
    idle(3);
    chk("pre-reset irq", {15'd0, irq_n}, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset irq", {15'd0, irq_n}, 16'h0001);
    chk("async reset dbg", dbg_count, 16'h0000);
    @(negedge m2);
    rst_n = 1'b1;
    idle(5);
    chk("post-reset halted dbg", dbg_count, 16'h0000);

    // Filtered A12 rises, up mode; loads 01/00 store FE/FF.
    do_write(3'd1, 8'h41, 1'b0);
    do_write(3'd4, 8'h01, 1'b0);
    do_write(3'd5, 8'h00, 1'b0);
    do_write(3'd3, 8'h00, 1'b0);
    chk("a12 load dbg", dbg_count, 16'hFFFE);
    ppu_a12 = 1'b1;
    idle(2);
    chk("a12 latency early", dbg_count, 16'hFFFE);
    idle(1);
    chk("a12 first rise", dbg_count, 16'hFFFF);
    ppu_a12 = 1'b0;
    idle(4);
    ppu_a12 = 1'b1;
    idle(2);
    ppu_a12 = 1'b0;
    idle(2);
    ppu_a12 = 1'b1;
    idle(2);
    ppu_a12 = 1'b0;
    idle(4);
    chk("a12 second rise dbg", dbg_count, 16'h0000);
    chk("a12 second rise irq", {15'd0, irq_n}, 16'h0000);

    // Mode change keeps edge history: an old rd_n fall must not tick.
    do_write(3'd0, 8'h00, 1'b0);
    chk("ack irq", {15'd0, irq_n}, 16'h0001);
    ppu_rd_n = 1'b0;
    idle(4);
    do_write(3'd1, 8'h82, 1'b0);
    idle(4);
    chk("mode switch no tick", dbg_count, 16'h0000);
    ppu_rd_n = 1'b1;
    idle(2);
    ppu_rd_n = 1'b0;
    idle(4);
    chk("rd fall tick dbg", dbg_count, 16'hFFFF);
    chk("rd fall disabled irq", {15'd0, irq_n}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
